ballot_station: RTL

Voter-facing front end that produces the `valid_vote`/`candidate` strobe consumed by the vote counter.
- A poll officer arms the station, and a single voter selects one candidate and confirms or cancels.
- The station emits exactly one single-cycle vote strobe per armed session, then locks until the officer re-arms.
- An inactivity timeout aborts abandoned sessions.

---
 rtl/voting_pkg.sv | 17 +
 rtl/onehot_encoder.sv | 30 +++
 rtl/ballot_station.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/voting_pkg.sv
// rtl/voting_pkg.sv - shared types and constants for the ballot station
// Purpose: station FSM state type, candidate index width, default candidate count.
// Ports: none (package).
package voting_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      SELECTED,
      CAST,
      LOCKED
   } station_state_t;

   localparam int CAND_ID_W = 4;
   localparam int MAX_CAND  = 16;

endpackage

// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - one-hot vector to index encoder
// Purpose: converts a candidate press vector to a zero-extended index and flags
//          whether exactly one bit is set.
// Ports:
//   i_vec        in  WIDTH      candidate vector
//   o_index      out CAND_ID_W  index of the set bit (meaningful when o_is_onehot)
//   o_is_onehot  out 1          exactly one bit of i_vec is set
module onehot_encoder
   import voting_pkg::*;
#(
   parameter int WIDTH = MAX_CAND
) (
   input  logic [WIDTH-1:0]     i_vec,
   output logic [CAND_ID_W-1:0] o_index,
   output logic                 o_is_onehot
);

   always_comb begin
      o_index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_vec[i]) begin
            o_index = CAND_ID_W'(i);
         end
      end
   end

   // Non-zero and clearing the lowest set bit leaves nothing.
   assign o_is_onehot = (i_vec != '0) && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/ballot_station.sv
// rtl/ballot_station.sv - voter-facing front end producing the vote strobe
// Purpose: officer arms a session, a voter selects one candidate and confirms
//          or cancels; exactly one vote strobe per arming, inactivity timeout.
// Ports:
//   clk              in  1         system clock, rising edge
//   reset            in  1         asynchronous active-high reset
//   officer_enable   in  1         level, authorises one session
//   cand_btn         in  NUM_CAND  candidate buttons (level)
//   confirm_btn      in  1         confirm button (level)
//   cancel_btn       in  1         cancel button (level)
//   valid_vote       out 1         one-cycle vote strobe
//   candidate        out 4         selected candidate index
//   ready            out 1         session open (ARMED or SELECTED)
//   selection_valid  out 1         a candidate is selected
//   timeout_pulse    out 1         one-cycle pulse on timeout abort
//   ballots_cast     out CNT_W     saturating strobe count
module ballot_station
   import voting_pkg::*;
#(
   parameter int NUM_CAND       = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 officer_enable,
   input  logic [NUM_CAND-1:0]  cand_btn,
   input  logic                 confirm_btn,
   input  logic                 cancel_btn,
   output logic                 valid_vote,
   output logic [CAND_ID_W-1:0] candidate,
   output logic                 ready,
   output logic                 selection_valid,
   output logic                 timeout_pulse,
   output logic [CNT_W-1:0]     ballots_cast
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   station_state_t        r_state;
   station_state_t        w_next_state;
   logic [NUM_CAND-1:0]   r_cand_prev;
   logic                  r_confirm_prev;
   logic                  r_cancel_prev;
   logic [TIMER_W-1:0]    r_timer;
   logic [CAND_ID_W-1:0]  r_candidate;
   logic [CNT_W-1:0]      r_count;

   logic [NUM_CAND-1:0]   w_cand_press;
   logic                  w_confirm_press;
   logic                  w_cancel_press;
   logic [CAND_ID_W-1:0]  w_sel_idx;
   logic                  w_sel_onehot;
   logic                  w_timer_clr;
   logic                  w_timer_inc;
   logic                  w_latch_cand;
   logic                  w_timeout;

   // Rising-edge detection: only fresh presses act, held levels are ignored.
   assign w_cand_press    = cand_btn & ~r_cand_prev;
   assign w_confirm_press = confirm_btn & ~r_confirm_prev;
   assign w_cancel_press  = cancel_btn & ~r_cancel_prev;

   onehot_encoder #(
      .WIDTH (NUM_CAND)
   ) u_onehot_encoder (
      .i_vec       (w_cand_press),
      .o_index     (w_sel_idx),
      .o_is_onehot (w_sel_onehot)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_cand_prev    <= '0;
         r_confirm_prev <= 1'b0;
         r_cancel_prev  <= 1'b0;
         r_timer        <= '0;
         r_candidate    <= '0;
         r_count        <= '0;
      end else begin
         r_state        <= w_next_state;
         r_cand_prev    <= cand_btn;
         r_confirm_prev <= confirm_btn;
         r_cancel_prev  <= cancel_btn;
         if (w_timer_clr) begin
            r_timer <= '0;
         end else if (w_timer_inc) begin
            r_timer <= r_timer + 1'b1;
         end
         if (w_latch_cand) begin
            r_candidate <= w_sel_idx;
         end
         // Count on leaving CAST, so a reset during the strobe never counts it.
         if (r_state == CAST && r_count != '1) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // Priority in an open session: withdrawal, cancel, confirm, candidate, timeout.
   always_comb begin
      w_next_state = r_state;
      w_timer_clr  = 1'b0;
      w_timer_inc  = 1'b0;
      w_latch_cand = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         IDLE: begin
            if (officer_enable) begin
               w_next_state = ARMED;
               w_timer_clr  = 1'b1;
            end
         end
         ARMED, SELECTED: begin
            if (!officer_enable) begin
               w_next_state = IDLE;
            end else if (w_cancel_press) begin
               w_next_state = LOCKED;
            end else if (w_confirm_press && r_state == SELECTED) begin
               w_next_state = CAST;
            end else if (w_sel_onehot) begin
               w_next_state = SELECTED;
               w_latch_cand = 1'b1;
               w_timer_clr  = 1'b1;
            end else if (r_timer == TIMER_LAST) begin
               w_next_state = LOCKED;
               w_timeout    = 1'b1;
            end else begin
               w_timer_inc  = 1'b1;
            end
         end
         CAST: begin
            w_next_state = LOCKED;
         end
         LOCKED: begin
            if (!officer_enable) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign valid_vote      = (r_state == CAST);
   assign ready           = (r_state == ARMED) || (r_state == SELECTED);
   assign selection_valid = (r_state == SELECTED);
   assign timeout_pulse   = w_timeout;
   assign candidate       = r_candidate;
   assign ballots_cast    = r_count;

endmodule
